// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential integer divider.
package div_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_t;

  // Signed variants take magnitudes and fix the signs afterwards.
  function automatic logic is_signed(input div_op_t op);
    return (op == DIV) || (op == REM);
  endfunction

  // Quotient-producing ops; the rest return the remainder.
  function automatic logic is_quot(input div_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] dividend_next
);

  logic [XLEN:0] shifted;
  logic          fits;

  // The running remainder stays below the divisor, so the difference always fits XLEN bits.
  always_comb begin
    shifted = {rem, dividend[XLEN-1]};
    fits    = (shifted >= {1'b0, divisor});
    if (fits) begin
      rem_next      = shifted[XLEN-1:0] - divisor;
      dividend_next = {dividend[XLEN-2:0], 1'b1};
    end else begin
      rem_next      = shifted[XLEN-1:0];
      dividend_next = {dividend[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_seq_divider.sv
// Multi-cycle DIV/DIVU/REM/REMU unit with valid/ready handshakes on both sides.
module mul_div_seq_divider
  import div_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Result,
  output logic            Div_by_zero,
  output logic            Overflow,
  output logic            busy
);

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  div_state_t      state_q, state_n;
  div_op_t         op_q, op_n, op_e;
  logic [XLEN-1:0] rem_q, rem_n;
  logic [XLEN-1:0] dvd_q, dvd_n;
  logic [XLEN-1:0] dvs_q, dvs_n;
  logic            neg_quo_q, neg_quo_n;
  logic            neg_rem_q, neg_rem_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [XLEN-1:0] result_q, result_n;
  logic            dbz_q, dbz_n;
  logic            ovf_q, ovf_n;
  logic            in_ready_q, in_ready_n;
  logic            out_valid_q, out_valid_n;
  logic            busy_q, busy_n;

  logic [XLEN-1:0] step_rem, step_dvd;
  logic [XLEN-1:0] quo_fix, rem_fix;
  logic            sgn;

  assign op_e = div_op_t'(op);
  assign sgn  = is_signed(op_e);

  div_step #(.XLEN(XLEN)) u_step (
    .rem           (rem_q),
    .dividend      (dvd_q),
    .divisor       (dvs_q),
    .rem_next      (step_rem),
    .dividend_next (step_dvd)
  );

  // Sign correction applied in FIX; the dividend register holds the quotient by then.
  assign quo_fix = neg_quo_q ? (XLEN'(0) - dvd_q) : dvd_q;
  assign rem_fix = neg_rem_q ? (XLEN'(0) - rem_q) : rem_q;

  // Next-state and datapath update; flush overrides everything except reset.
  always_comb begin
    state_n   = state_q;
    op_n      = op_q;
    rem_n     = rem_q;
    dvd_n     = dvd_q;
    dvs_n     = dvs_q;
    neg_quo_n = neg_quo_q;
    neg_rem_n = neg_rem_q;
    cnt_n     = cnt_q;
    result_n  = result_q;
    dbz_n     = dbz_q;
    ovf_n     = ovf_q;

    if (flush) begin
      state_n = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_n = op_e;
            if (B == '0) begin
              result_n = is_quot(op_e) ? ALL_ONES : A;
              dbz_n    = 1'b1;
              ovf_n    = 1'b0;
              state_n  = DONE;
            end else if (sgn && (A == MOST_NEG) && (B == ALL_ONES)) begin
              result_n = is_quot(op_e) ? A : '0;
              dbz_n    = 1'b0;
              ovf_n    = 1'b1;
              state_n  = DONE;
            end else begin
              dvd_n     = (sgn && A[XLEN-1]) ? (XLEN'(0) - A) : A;
              dvs_n     = (sgn && B[XLEN-1]) ? (XLEN'(0) - B) : B;
              neg_quo_n = sgn & (A[XLEN-1] ^ B[XLEN-1]);
              neg_rem_n = sgn & A[XLEN-1];
              rem_n     = '0;
              cnt_n     = CNT_W'(XLEN);
              state_n   = CALC;
            end
          end
        end
        CALC: begin
          rem_n = step_rem;
          dvd_n = step_dvd;
          cnt_n = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_n = FIX;
          end
        end
        FIX: begin
          result_n = is_quot(op_q) ? quo_fix : rem_fix;
          dbz_n    = 1'b0;
          ovf_n    = 1'b0;
          state_n  = DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    in_ready_n  = (state_n == IDLE);
    out_valid_n = (state_n == DONE);
    busy_n      = (state_n == CALC) || (state_n == FIX);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= DIV;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      op_q        <= op_n;
      rem_q       <= rem_n;
      dvd_q       <= dvd_n;
      dvs_q       <= dvs_n;
      neg_quo_q   <= neg_quo_n;
      neg_rem_q   <= neg_rem_n;
      cnt_q       <= cnt_n;
      result_q    <= result_n;
      dbz_q       <= dbz_n;
      ovf_q       <= ovf_n;
      in_ready_q  <= in_ready_n;
      out_valid_q <= out_valid_n;
      busy_q      <= busy_n;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign Result      = result_q;
  assign Div_by_zero = dbz_q;
  assign Overflow    = ovf_q;

endmodule

// File: tb/tb_mul_div_seq_divider.sv
// Directed plus randomized checks of the sequential divider against an arithmetic reference.
module tb_mul_div_seq_divider;
  import div_pkg::*;

  localparam int unsigned W = 64;
  localparam logic [W-1:0] MNEG = 64'h8000_0000_0000_0000;
  localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Result;
  logic         Div_by_zero;
  logic         Overflow;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  mul_div_seq_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .A           (A),
    .B           (B),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .Result      (Result),
    .Div_by_zero (Div_by_zero),
    .Overflow    (Overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V division semantics from plain arithmetic.
  function automatic void model(input div_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] res, output logic dz, output logic ov);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    dz = 1'b0;
    ov = 1'b0;
    res = '0;
    if (b == '0) begin
      dz  = 1'b1;
      res = (o == DIV || o == DIVU) ? ONES : a;
    end else if ((o == DIV || o == REM) && a == MNEG && b == ONES) begin
      ov  = 1'b1;
      res = (o == DIV) ? a : '0;
    end else begin
      case (o)
        DIV:  res = W'(sa / sb);
        REM:  res = W'(sa % sb);
        DIVU: res = a / b;
        default: res = a % b;
      endcase
    end
  endfunction

  // Issue one op, check latency, result, flags, optional backpressure, then consume.
  task automatic do_op(input div_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, input string tag);
    logic [W-1:0] er;
    logic         ed;
    logic         eo;
    int           lat;
    int           exp_lat;
    model(o, a, b, er, ed, eo);
    exp_lat = (ed || eo) ? 0 : W + 1;
    @(negedge clk);
    check({tag, " in_ready_idle"}, W'(in_ready), W'(1));
    op = o; A = a; B = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (exp_lat != 0) check({tag, " busy_calc"}, W'(busy), W'(1));
    check({tag, " in_ready_after_accept"}, W'(in_ready), W'(0));
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, " latency"}, W'(lat), W'(exp_lat));
    check({tag, " result"}, Result, er);
    check({tag, " div_by_zero"}, W'(Div_by_zero), W'(ed));
    check({tag, " overflow"}, W'(Overflow), W'(eo));
    check({tag, " busy_done"}, W'(busy), W'(0));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, " hold_valid"}, W'(out_valid), W'(1));
      check({tag, " hold_result"}, Result, er);
      check({tag, " hold_flags"}, W'({Div_by_zero, Overflow}), W'({ed, eo}));
      check({tag, " hold_in_ready"}, W'(in_ready), W'(0));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, " consumed_valid"}, W'(out_valid), W'(0));
    check({tag, " consumed_in_ready"}, W'(in_ready), W'(1));
  endtask

  initial begin
    div_op_t      ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bit           seen;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 2'b00; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", W'(out_valid), W'(0));
    check("reset result", Result, W'(0));
    check("reset flags", W'({Div_by_zero, Overflow}), W'(0));
    check("reset busy", W'(busy), W'(0));
    check("reset in_ready", W'(in_ready), W'(1));
    @(negedge clk) rst_n = 1'b1;

    // Basic, signed-sign, unsigned-wide and special cases.
    do_op(DIV,  64'd100, 64'd7, 0, "div_100_7");
    do_op(REM,  64'd100, 64'd7, 0, "rem_100_7");
    do_op(DIV,  -64'sd100, 64'sd7, 0, "div_m100_7");
    do_op(REM,  -64'sd100, 64'sd7, 0, "rem_m100_7");
    do_op(REM,  64'sd100, -64'sd7, 0, "rem_100_m7");
    do_op(DIV,  -64'sd100, -64'sd7, 0, "div_m100_m7");
    do_op(DIVU, ONES, 64'd2, 0, "divu_max_2");
    do_op(REMU, ONES, 64'd2, 0, "remu_max_2");
    do_op(DIV,  64'd5, 64'd0, 0, "div_5_0");
    do_op(REMU, 64'd5, 64'd0, 0, "remu_5_0");
    do_op(DIV,  MNEG, ONES, 0, "div_ovf");
    do_op(REM,  MNEG, ONES, 0, "rem_ovf");
    do_op(DIVU, MNEG, ONES, 0, "divu_mneg_ones");
    do_op(DIV,  64'd1000, 64'd33, 5, "backpressure");

    // Flush during CALC: blocks the concurrent request and drops the operation.
    @(negedge clk);
    op = DIV; A = 64'd100; B = 64'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = DIV; A = 64'd9; B = 64'd3;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    check("flush in_ready", W'(in_ready), W'(1));
    check("flush busy", W'(busy), W'(0));
    seen = 1'b0;
    repeat (70) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1'b1;
    end
    check("flush no_valid", W'(seen), W'(0));
    do_op(DIV, 64'd9, 64'd3, 0, "post_flush");

    // Reset in the middle of CALC.
    @(negedge clk);
    op = DIV; A = -64'sd100; B = 64'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset out_valid", W'(out_valid), W'(0));
    check("midreset result", Result, W'(0));
    check("midreset flags", W'({Div_by_zero, Overflow}), W'(0));
    check("midreset busy", W'(busy), W'(0));
    @(negedge clk) rst_n = 1'b1;

    // Flush in DONE wins over out_ready; the result is dropped.
    @(negedge clk);
    op = DIV; A = 64'd5; B = 64'd0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("flushdone valid_before", W'(out_valid), W'(1));
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; out_ready = 1'b0;
    check("flushdone valid_after", W'(out_valid), W'(0));
    check("flushdone in_ready", W'(in_ready), W'(1));

    // Randomized operands, biased toward sign and boundary corners.
    for (int n = 0; n < 40; n++) begin
      ro = div_op_t'($urandom_range(0, 3));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 6))
        0: rb = W'($urandom_range(0, 15));
        1: begin ra = W'($urandom_range(0, 1000)); rb = W'($urandom_range(1, 40)); end
        2: rb = '0;
        3: begin ra = MNEG; rb = ONES; end
        4: rb = W'(0) - W'($urandom_range(1, 300));
        5: rb = rb >> $urandom_range(1, 60);
        default: ;
      endcase
      do_op(ro, ra, rb, $urandom_range(0, 2), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_div_seq_divider.md
Name: mul_div_seq_divider

Overview:
- Multi-cycle 64-bit integer divide/remainder unit in the EX stage, alongside the single-cycle ALU.
- Takes the same A/B operand bus the ALU consumes and handles the RISC-V DIV, DIVU, REM and REMU operations.
- Its registered result feeds the EX result mux downstream.
- Valid/ready handshakes on both sides let the hazard unit stall the pipeline while it is busy.

Parameters:
- XLEN, 64, operand/result width; must be even and ≥ 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  pipeline flush; abort current operation
- in_valid  in  1  operands/op valid
- in_ready  out  1  unit can accept (high only in IDLE)
- op  in  2  div_op_t: DIV=00, DIVU=01, REM=10, REMU=11
- A  in  XLEN  dividend
- B  in  XLEN  divisor
- out_valid  out  1  Result valid, held until consumed
- out_ready  in  1  downstream consumes Result
- Result  out  XLEN  quotient or remainder per op
- Div_by_zero  out  1  B was zero; qualified by out_valid
- Overflow  out  1  signed DIV/REM with A = most-negative and B = -1; qualified by out_valid
- busy  out  1  state is CALC or FIX

Behaviour:
- Reset (rst_n=0 at an edge):
  - State goes to IDLE.
  - out_valid, Result, Div_by_zero, Overflow, busy and the counter all go to 0.
  - Reset has priority over everything; a reset mid-operation discards it.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - Accept edge E0 is an edge with in_valid=1 and flush=0; it latches op and the operands.
  - Special cases are resolved at E0 and go straight to DONE, so out_valid is visible in the cycle after E0:
    - B==0: quotient = all-ones, remainder = A, Div_by_zero=1.
    - Signed op with A==2^(XLEN-1) and B==all-ones: quotient = A, remainder = 0, Overflow=1.
  - Otherwise:
    - Load |A| and |B| for signed ops, raw values for unsigned ops.
    - Record neg_q = A[msb]^B[msb] and neg_r = A[msb] (both signed only).
    - Clear the remainder, set counter = XLEN, go to CALC.
- CALC: restoring radix-2, one quotient bit per edge.
  - Shift {rem, dividend} left by 1.
  - If rem ≥ divisor: rem -= divisor, set q bit 1.
  - Decrement the counter; after XLEN iterations go to FIX.
  - |most-negative| = 2^(XLEN-1) fits unsigned, so no extra width is needed beyond an XLEN+1-bit compare/subtract.
- FIX (one edge):
  - Negate the quotient if neg_q; negate the remainder if neg_r.
  - Select quotient (DIV/DIVU) or remainder (REM/REMU) into Result.
  - Go to DONE.
- Normal latency: out_valid rises after edge E0+XLEN+1, i.e. 65 cycles for XLEN=64.
- DONE:
  - out_valid=1; Result and flags are held stable while out_ready=0.
  - Edge with out_ready=1: go to IDLE, out_valid=0.
  - in_ready=0 in DONE, so there is no same-cycle accept.
- flush=1 at an edge, in any non-reset state:
  - Go to IDLE and clear out_valid.
  - flush beats in_valid in the same cycle, so the operation is not accepted.
  - flush beats out_ready in DONE; the result is dropped.
- Result and flag registers change only on the transition into DONE or on reset.
- busy=1 exactly while in CALC or FIX.
- Sign convention: the remainder takes the sign of the dividend, and the quotient truncates toward zero.

Decomposition:
- Package div_pkg:
  - XLEN_DEFAULT.
  - div_op_t enum (DIV, DIVU, REM, REMU).
  - div_state_t enum (IDLE, CALC, FIX, DONE).
  - Helper function is_signed(op).
- One sub-module, div_step: the combinational restoring-iteration datapath.
  - Inputs: rem, dividend, divisor.
  - Outputs: next rem, next dividend/quotient.
  - Instantiated once inside the FSM module.

Test Plan:
- DIV A=100, B=7: Result=14, out_valid exactly 65 cycles after accept; REM same operands gives Result=2.
- Signed signs: DIV A=-100, B=7 gives -14; REM gives -2; REM A=100, B=-7 gives 2; DIV A=-100, B=-7 gives 14.
- DIVU A=0xFFFF_FFFF_FFFF_FFFF, B=2: Result=0x7FFF_FFFF_FFFF_FFFF; REMU gives 1; Div_by_zero=0, Overflow=0.
- Special cases, each with out_valid 1 cycle after accept:
  - DIV 5/0 gives Result=all-ones, Div_by_zero=1.
  - REMU 5/0 gives Result=5.
  - DIV 0x8000_0000_0000_0000 / -1 gives Result=0x8000_0000_0000_0000, Overflow=1.
  - REM of the same operands gives 0.
- Flush and reset:
  - flush at cycle 10 of CALC: out_valid never asserts, in_ready=1 the next cycle, and a new DIV 9/3 then gives 3.
  - rst_n=0 mid-CALC: all outputs are 0 the next cycle.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - Result, flags and out_valid stay stable and in_ready=0.
  - Raising out_ready returns the unit to IDLE on that edge.
